// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin shared binary<->Gray conversion stage
module gray_conv_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_data,
    input  logic [NREQ-1:0]   req_g2b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [IDW-1:0]    out_id
);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] id_q;
    logic [N-1:0]   op_q;
    logic           g2b_q;
    logic [N-1:0]   out_data_q;
    logic [IDW-1:0] out_id_q;
    logic           out_valid_q;

    logic           win_any_d;
    logic [IDW-1:0] win_id_d;
    int             cand;

    function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int k = N - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Scan starting just after the last served requester so it ranks lowest.
    always_comb begin
        win_any_d = 1'b0;
        win_id_d  = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!win_any_d && req_valid[cand]) begin
                win_any_d = 1'b1;
                win_id_d  = IDW'(cand);
            end
        end
    end

    assign req_ready = (state_q == IDLE && win_any_d && !rst) ? (NREQ'(1) << win_id_d) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            op_q        <= '0;
            g2b_q       <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_any_d) begin
                        op_q    <= req_data[win_id_d*N +: N];
                        g2b_q   <= req_g2b[win_id_d];
                        id_q    <= win_id_d;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    out_data_q  <= g2b_q ? gray_to_bin(op_q) : (op_q ^ (op_q >> 1));
                    out_id_q    <= id_q;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        ptr_q       <= out_id_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - scoreboard bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [3:0]  req_g2b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;

    int n_vec   = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;
    int n_abort = 0;

    logic [9:0] exp_q[$];
    int gexp[5] = '{0, 1, 2, 3, 0};
    logic [7:0] t3_out[4] = '{8'h00, 8'h80, 8'hFF, 8'hB4};

    gray_conv_arbiter #(.N(8), .NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_g2b(req_g2b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_b2g(input logic [7:0] d);
        return d ^ {1'b0, d[7:1]};
    endfunction

    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_q.push_back({2'(id), d});
        n_push++;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: got id %0d data %0h expected none", out_id, out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                n_pop++;
                check("out_id", 32'(out_id), 32'(e[9:8]));
                check("out_data", 32'(out_data), 32'(e[7:0]));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic issue(input int id, input logic [7:0] d, input logic g, input logic [7:0] exp);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_data[id*8 +: 8] = d;
        req_g2b[id]         = g;
        req_valid[id]       = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (req_ready == (4'b1 << id)) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("issue_grant", 32'(got), 32'd1);
        if (got) push_exp(id, exp);
        @(posedge clk); #1 req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_out_valid(input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [3:0] pend;
        logic [7:0] rdat[4];
        logic       rg[4];
        int         waitc[4];
        int         grants;
        int         ng;
        int         w;
        bit         acc;

        rst = 1'b1; req_valid = 4'hF; req_data = '0; req_g2b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        rst = 1'b0;

        // Directed single request with exact latency
        @(posedge clk); #1;
        req_data[7:0] = 8'hB4; req_g2b[0] = 1'b0; req_valid = 4'b0001;
        #1 check("t1_req_ready", 32'(req_ready), 32'h1);
        push_exp(0, 8'hEE);
        @(posedge clk); #1 req_valid = 4'b0000;
        check("t1_conv_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'hEE);
        check("t1_out_id", 32'(out_id), 32'd0);
        @(posedge clk); #1;
        check("t1_after_hs", 32'(out_valid), 32'd0);

        issue(2, 8'hEE, 1'b1, 8'hB4);
        issue(1, 8'hFF, 1'b0, 8'h80);
        issue(3, 8'h00, 1'b0, 8'h00);
        issue(0, 8'h80, 1'b1, 8'hFF);
        issue(2, 8'h00, 1'b1, 8'h00);
        issue(3, 8'hFF, 1'b1, 8'hAA);
        issue(1, 8'hAA, 1'b0, 8'hFF);
        drain();

        // All four requesters held high after reset
        do_reset();
        req_data = {8'hEE, 8'h80, 8'hFF, 8'h00};
        req_g2b  = 4'b1100;
        req_valid = 4'hF;
        ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            @(negedge clk);
            if (req_ready != 4'h0) begin
                check("t3_onehot", 32'($onehot(req_ready)), 32'd1);
                w = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) w = i;
                check("t3_order", 32'(w), 32'(gexp[ng]));
                push_exp(w, t3_out[w]);
                ng++;
            end
        end
        check("t3_grants", 32'(ng), 32'd5);
        @(posedge clk); #1 req_valid = 4'h0;
        drain();

        // Downstream stall
        out_ready = 1'b0;
        issue(1, 8'h5A, 1'b0, 8'h77);
        wait_out_valid("t4_valid_seen");
        req_data[31:24] = 8'h01; req_valid = 4'b1000;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data", 32'(out_data), 32'h77);
            check("t4_hold_id", 32'(out_id), 32'd1);
            check("t4_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 req_valid = 4'h0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_released", 32'(out_valid), 32'd0);
        drain();

        // Reset while holding a result
        out_ready = 1'b0;
        issue(2, 8'h33, 1'b0, 8'h2A);
        wait_out_valid("t5_valid_seen");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data", 32'(out_data), 32'd0);
        check("t5_id", 32'(out_id), 32'd0);
        n_abort += exp_q.size();
        exp_q.delete();
        out_ready = 1'b1;
        req_data[23:0] = {8'h11, 8'h22, 8'h0F};
        req_g2b = 4'b0000;
        req_valid = 4'b0111;
        #1 check("t5_first_grant", 32'(req_ready), 32'h1);
        push_exp(0, 8'h08);
        @(posedge clk); #1 req_valid = 4'h0;
        drain();

        // Random traffic with reference conversion
        pend = '0; acc = 0; w = 0; grants = 0;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 20000 && grants < 1000; cyc++) begin
            @(posedge clk); #1;
            if (acc) begin
                pend[w] = 1'b0;
                acc = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]  = 1'b1;
                    rdat[i]  = 8'($urandom);
                    rg[i]    = 1'($urandom);
                    waitc[i] = 0;
                end
                req_data[i*8 +: 8] = rdat[i];
                req_g2b[i]         = rg[i];
            end
            req_valid = pend;
            out_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            if (req_ready != 4'h0) begin
                check("rnd_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < 4; i++) if (req_ready[i]) w = i;
                check("rnd_pending", 32'(pend[w]), 32'd1);
                check("rnd_starve", 32'(waitc[w] <= 3), 32'd1);
                for (int i = 0; i < 4; i++) if (i != w && pend[i]) waitc[i]++;
                push_exp(w, rg[w] ? ref_g2b(rdat[w]) : ref_b2g(rdat[w]));
                acc = 1;
                grants++;
            end
        end
        check("rnd_grants", 32'(grants), 32'd1000);
        @(posedge clk); #1 req_valid = 4'h0; out_ready = 1'b1;
        drain();
        check("no_lost_dup", 32'(n_pop), 32'(n_push - n_abort));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
